// File: rtl/ascon_block_packer.sv
// Byte-stream to 64-bit rate-block packer for the ASCON-128 control FSM.
// Big-endian lane packing with 10* padding and per-segment block indexing.
module ascon_block_packer #(
    parameter int          BLK_W    = 2,
    parameter logic [7:0]  PAD_BYTE = 8'h80
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    input  logic             byte_last_i,
    input  logic             seg_i,
    input  logic             empty_i,
    output logic             byte_ready_o,
    output logic [63:0]      data_o,
    output logic             data_valid_o,
    output logic             data_last_o,
    output logic             data_pad_o,
    output logic             data_seg_o,
    output logic [BLK_W-1:0] block_o,
    input  logic             data_ack_i
);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    localparam logic [63:0]      PAD_BLK = {PAD_BYTE, 56'h0};
    localparam logic [BLK_W-1:0] BLK_MAX = {BLK_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic [63:0]      r_data;
    logic [63:0]      w_data_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_pad;
    logic             w_pad_nxt;
    logic             r_seg;
    logic             w_seg_nxt;
    logic [BLK_W-1:0] r_blk;
    logic [BLK_W-1:0] w_blk_nxt;

    logic             w_empty;
    logic             w_ready;
    logic             w_take;
    logic [5:0]       w_shift;
    logic [63:0]      w_byte_word;
    logic [63:0]      w_pad_word;
    logic [BLK_W-1:0] w_blk_inc;

    assign w_empty     = (r_state == S_FILL) && empty_i && (r_cnt == 3'd0);
    assign w_ready     = resetb_i && (r_state == S_FILL) && !w_empty;
    assign w_take      = byte_valid_i && w_ready;
    // lane cnt sits (7-cnt) bytes above the LSB; ~cnt is 7-cnt for 3 bits
    assign w_shift     = {~r_cnt, 3'b000};
    assign w_byte_word = {56'h0, byte_i} << w_shift;
    assign w_pad_word  = ({56'h0, PAD_BYTE} << w_shift) >> 8;
    assign w_blk_inc   = (r_blk == BLK_MAX) ? r_blk : r_blk + 1'b1;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_cnt  <= 3'd0;
            r_pend <= 1'b0;
            r_data <= 64'h0;
            r_last <= 1'b0;
            r_pad  <= 1'b0;
            r_seg  <= 1'b0;
            r_blk  <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pend <= w_pend_nxt;
            r_data <= w_data_nxt;
            r_last <= w_last_nxt;
            r_pad  <= w_pad_nxt;
            r_seg  <= w_seg_nxt;
            r_blk  <= w_blk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_pad_nxt   = r_pad;
        w_seg_nxt   = r_seg;
        w_blk_nxt   = r_blk;
        unique case (r_state)
            S_FILL: begin
                if (w_empty) begin
                    w_data_nxt  = PAD_BLK;
                    w_last_nxt  = 1'b1;
                    w_pad_nxt   = 1'b1;
                    w_seg_nxt   = seg_i;
                    w_state_nxt = S_HOLD;
                end else if (w_take) begin
                    w_data_nxt = ((r_cnt == 3'd0) ? 64'h0 : r_data) | w_byte_word;
                    w_cnt_nxt  = r_cnt + 3'd1;
                    w_last_nxt = 1'b0;
                    w_pad_nxt  = 1'b0;
                    if (r_cnt == 3'd0) begin
                        w_seg_nxt = seg_i;
                    end
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = S_HOLD;
                        w_pend_nxt  = byte_last_i;
                    end else if (byte_last_i) begin
                        w_data_nxt  = r_data & 64'h0 | w_data_nxt | w_pad_word;
                        w_last_nxt  = 1'b1;
                        w_pad_nxt   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (data_ack_i) begin
                    if (r_pend) begin
                        // full final block: follow with a padding-only block
                        w_data_nxt = PAD_BLK;
                        w_last_nxt = 1'b1;
                        w_pad_nxt  = 1'b1;
                        w_pend_nxt = 1'b0;
                        w_blk_nxt  = w_blk_inc;
                    end else if (r_last) begin
                        w_blk_nxt   = '0;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_FILL;
                    end else begin
                        w_blk_nxt   = w_blk_inc;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign byte_ready_o = w_ready;
    assign data_o       = r_data;
    assign data_valid_o = (r_state == S_HOLD);
    assign data_last_o  = r_last;
    assign data_pad_o   = r_pad;
    assign data_seg_o   = r_seg;
    assign block_o      = r_blk;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed table-driven bench for ascon_block_packer.
// Vectors carry input bytes and hand-computed packed blocks.
module tb_ascon_block_packer;

    logic        clk;
    logic        rstn;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic        seg_i;
    logic        empty_i;
    logic        byte_ready_o;
    logic [63:0] data_o;
    logic        data_valid_o;
    logic        data_last_o;
    logic        data_pad_o;
    logic        data_seg_o;
    logic [1:0]  block_o;
    logic        data_ack_i;

    int checks;
    int failures;

    ascon_block_packer #(.BLK_W(2), .PAD_BYTE(8'h80)) dut (
        .clock_i      (clk),
        .resetb_i     (rstn),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_last_i  (byte_last_i),
        .seg_i        (seg_i),
        .empty_i      (empty_i),
        .byte_ready_o (byte_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o),
        .data_pad_o   (data_pad_o),
        .data_seg_o   (data_seg_o),
        .block_o      (block_o),
        .data_ack_i   (data_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           n;
        logic [191:0] b;
        logic         seg;
        logic [191:0] e;
        int           nb;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last,
                             input logic seg);
        int n;
        byte_i       = b;
        byte_last_i  = last;
        seg_i        = seg;
        byte_valid_i = 1'b1;
        #1;
        n = 0;
        while (!byte_ready_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("byte_ready", {63'h0, byte_ready_o}, 64'h1);
        @(negedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic check_block(input string name, input logic [63:0] d,
                               input logic last, input logic pad,
                               input logic seg, input logic [1:0] blk);
        int n;
        n = 0;
        while (!data_valid_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_valid"}, {63'h0, data_valid_o}, 64'h1);
        chk({name, "_data"}, data_o, d);
        chk({name, "_last"}, {63'h0, data_last_o}, {63'h0, last});
        chk({name, "_pad"}, {63'h0, data_pad_o}, {63'h0, pad});
        chk({name, "_seg"}, {63'h0, data_seg_o}, {63'h0, seg});
        chk({name, "_blk"}, {62'h0, block_o}, {62'h0, blk});
        data_ack_i = 1'b1;
        @(negedge clk);
        #1;
        data_ack_i = 1'b0;
    endtask

    initial begin
        int j;
        logic [63:0] exp;
        logic [63:0] held;
        checks       = 0;
        failures     = 0;
        rstn         = 1'b0;
        byte_i       = 8'h0;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        seg_i        = 1'b0;
        empty_i      = 1'b0;
        data_ack_i   = 1'b0;

        tv[0] = '{5, {40'h3230323033, 152'h0}, 1'b0,
                  {64'h3230323033800000, 128'h0}, 1};
        tv[1] = '{8, {64'h0001020304050607, 128'h0}, 1'b1,
                  {128'h0001020304050607_8000000000000000, 64'h0}, 2};
        tv[2] = '{20, {160'h1011121314151617_18191A1B1C1D1E1F_20212223, 32'h0},
                  1'b1,
                  {192'h1011121314151617_18191A1B1C1D1E1F_2021222380000000}, 3};
        tv[3] = '{7, {56'h01020304050607, 136'h0}, 1'b0,
                  {64'h0102030405060780, 128'h0}, 1};
        tv[4] = '{1, {8'h5A, 184'h0}, 1'b0,
                  {64'h5A80000000000000, 128'h0}, 1};
        tv[5] = '{16, {128'h4041424344454647_48494A4B4C4D4E4F, 64'h0}, 1'b0,
                  {192'h4041424344454647_48494A4B4C4D4E4F_8000000000000000}, 3};

        @(negedge clk);
        #1;
        chk("rst_ready", {63'h0, byte_ready_o}, 64'h0);
        chk("rst_valid", {63'h0, data_valid_o}, 64'h0);
        chk("rst_data", data_o, 64'h0);
        chk("rst_flags", {60'h0, data_last_o, data_pad_o, block_o}, 64'h0);
        chk("rst_seg", {63'h0, data_seg_o}, 64'h0);
        rstn = 1'b1;
        @(negedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            j = 0;
            for (int k = 0; k < tv[v].n; k++) begin
                send_byte(tv[v].b[191-8*k -: 8], k == tv[v].n - 1, tv[v].seg);
                while (data_valid_o && j < tv[v].nb) begin
                    check_block($sformatf("v%0d_b%0d", v, j),
                                tv[v].e[191-64*j -: 64],
                                j == tv[v].nb - 1, j == tv[v].nb - 1,
                                tv[v].seg, 2'(j));
                    j++;
                end
            end
            chk($sformatf("v%0d_nblk", v), 64'(j), 64'(tv[v].nb));
            chk($sformatf("v%0d_blk0", v), {62'h0, block_o}, 64'h0);
            chk($sformatf("v%0d_ready", v), {63'h0, byte_ready_o}, 64'h1);
        end

        // empty request beats a simultaneous byte
        empty_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_i       = 8'h77;
        byte_last_i  = 1'b1;
        seg_i        = 1'b1;
        #1;
        chk("empty_ready", {63'h0, byte_ready_o}, 64'h0);
        @(negedge clk);
        #1;
        empty_i = 1'b0;
        chk("empty_hold_ready", {63'h0, byte_ready_o}, 64'h0);
        check_block("empty", 64'h8000000000000000, 1'b1, 1'b1, 1'b1, 2'd0);
        chk("empty_byte_ready", {63'h0, byte_ready_o}, 64'h1);
        @(negedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        check_block("after_empty", 64'h7780000000000000, 1'b1, 1'b1,
                    1'b1, 2'd0);

        // backpressure: block held for 10 cycles, pending byte not consumed
        for (int k = 0; k < 8; k++) begin
            send_byte(8'(k + 1), 1'b0, 1'b0);
        end
        byte_valid_i = 1'b1;
        byte_i       = 8'h99;
        byte_last_i  = 1'b1;
        held         = data_o;
        chk("bp_first", held, 64'h0102030405060708);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_c%0d", c),
                {data_o[62:0], data_valid_o ^ 1'b1} ^ {held[62:0], 1'b0} |
                {63'h0, byte_ready_o}, 64'h0);
        end
        check_block("bp_blk0", 64'h0102030405060708, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        check_block("bp_blk1", 64'h9980000000000000, 1'b1, 1'b1, 1'b0, 2'd1);
        chk("bp_blk_clr", {62'h0, block_o}, 64'h0);

        // block index saturation over a 40-byte segment plus pad block
        for (int k = 0; k < 40; k++) begin
            send_byte(8'(k), k == 39, 1'b1);
            if (data_valid_o) begin
                j = k / 8;
                for (int m = 0; m < 8; m++) begin
                    exp[63-8*m -: 8] = 8'(8 * j + m);
                end
                check_block($sformatf("sat_b%0d", j), exp, 1'b0, 1'b0, 1'b1,
                            (j > 3) ? 2'd3 : 2'(j));
            end
        end
        check_block("sat_pad", 64'h8000000000000000, 1'b1, 1'b1, 1'b1, 2'd3);
        chk("sat_blk_clr", {62'h0, block_o}, 64'h0);

        // reset mid-block discards the partial block
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", {63'h0, byte_ready_o}, 64'h0);
        chk("mid_rst_data", data_o, 64'h0);
        chk("mid_rst_flags",
            {59'h0, data_valid_o, data_last_o, data_pad_o, block_o}, 64'h0);
        chk("mid_rst_seg", {63'h0, data_seg_o}, 64'h0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        data_ack_i = 1'b1;
        @(negedge clk);
        #1;
        data_ack_i = 1'b0;
        chk("idle_ack", {61'h0, data_valid_o, block_o}, 64'h0);
        for (int k = 0; k < 8; k++) begin
            send_byte(8'hAA, k == 7, 1'b0);
        end
        check_block("aa_blk0", 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0, 1'b0, 2'd0);
        check_block("aa_blk1", 64'h8000000000000000, 1'b1, 1'b1, 1'b0, 2'd1);
        chk("aa_ready", {63'h0, byte_ready_o}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
